ldpc_bf_decoder: RTL and testbench
==================================

# ldpc_bf_decoder

Parametrised (16,8) LDPC codec with iterative hard-decision bit-flipping decode, valid/ready streaming on both sides, run-time iteration limit and selectable flip rule. It is the next-generation codec in the ECC library, sitting between the data source and the channel model/test harness. Versus the earlier fixed-latency LDPC codec it adds:
- one-cycle iterations
- early termination with iteration count reporting
- threshold flipping
- output backpressure

## Interface
Parameters:
- MAX_ITER_LIMIT, 15: largest legal cfg_max_iter; cfg_max_iter above this is clamped to it.
- ITER_W, 4: width of iteration counter and cfg_max_iter; must satisfy 2^ITER_W > MAX_ITER_LIMIT.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_encode  in  1  1 = encode in_data, 0 = decode in_codeword.
- in_data  in  8  message for encode.
- in_codeword  in  16  received word for decode; [7:0] = data u, [15:8] = parity p.
- cfg_max_iter  in  ITER_W  flip-iteration limit; sampled at accept.
- cfg_mode  in  1  0 = max-vote flip, 1 = threshold flip; sampled at accept.
- cfg_threshold  in  3  vote threshold for mode 1; sampled at accept.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer ready.
- out_codeword  out  16  encoded word, or final decoded word.
- out_data  out  8  out_codeword[7:0].
- out_iter  out  ITER_W  flips performed (0 for encode).
- out_corrected  out  1  decode converged and final word differs from received word.
- out_uncorrectable  out  1  syndrome nonzero when the limit is reached.

## Operation
- Parity: p[i] = XOR of u bits in check row i. Syndrome s[i] = that XOR ^ p[i].
  - row 0 {u0,u1,u2,u3}
  - row 1 {u0,u1,u4,u5}
  - row 2 {u0,u2,u4,u6}
  - row 3 {u0,u3,u4,u7}
  - row 4 {u1,u2,u5,u6}
  - row 5 {u1,u3,u5,u7}
  - row 6 {u2,u3,u6,u7}
  - row 7 {u0,u1,u2,u4,u6}
- Votes (3-bit unsigned sums of s):
  - u0: s0..s3,s7
  - u1: s0,s1,s4,s5,s7
  - u2: s0,s2,s4,s6,s7
  - u3: s0,s3,s5,s6
  - u4: s1,s2,s3,s7
  - u5: s1,s4,s5
  - u6: s2,s4,s6,s7
  - u7: s3,s5,s6
  - p[k]: s[k]
- Flip mask:
  - mode 0: all bits whose vote equals the maximum vote, if the maximum is > 0.
  - mode 1: all bits with vote >= cfg_threshold. cfg_threshold = 0 is treated as 1. An empty mask flips nothing but still counts as an iteration.
- State machine IDLE, ITER, OUT.
  - IDLE: in_ready = 1.
    - Encode accept: load the result and go to OUT.
    - Decode accept: latch the word, received copy and cfg fields; clear the counter; go to ITER.
  - ITER: one evaluation per cycle, combinational syndrome of the current word.
    - s == 0: converged, go to OUT.
    - Else if counter == latched limit: uncorrectable, go to OUT with the word unchanged.
    - Else: word ^= mask, counter += 1, stay in ITER.
  - OUT: out_valid = 1 with all out_* stable. Return to IDLE on out_ready.
- in_ready = 1 only in IDLE. No new request is accepted while a result is pending.
- out_corrected and out_uncorrectable are mutually exclusive; both are 0 for encode.
- Reset (rst_n low at a clock edge):
  - state IDLE, all outputs 0, in_ready 0 during reset.
  - An in-flight decode is discarded and no output is produced.

## Timing
- Request accepted at edge T.
- Encode: out_valid at T+1.
- Decode converging after k flips: out_valid at T+2+k, out_iter = k.
- Decode failing: out_valid at T+2+limit, out_iter = limit.
- Output handshake at edge U (out_valid && out_ready): out_valid drops at U+1, in_ready rises at U+1. The next accept is possible at U+1.
- Continuous-stream throughput is 1 request per 2 cycles for encode.
- Outputs are fully registered. No combinational path from in_* or out_ready to out_*. in_ready depends only on state.

## Test plan
- Reset, then encode in_data 0x01 -> out_codeword 0x8F01 at T+1, out_iter 0, both flags 0. Encode 0xA5 -> 0x00A5.
- Decode 0x00A5 (clean) -> out_valid at T+2, out_codeword 0x00A5, out_iter 0, out_corrected 0.
- Decode 0x00A4 (u0 error), mode 0, limit 10 -> votes u0 = 5 (unique max); out_data 0xA5, out_iter 1, out_corrected 1, out_valid at T+3.
- Decode 0x00A4, mode 1:
  - threshold 5 -> corrected to 0x00A5 with out_iter 1.
  - limit 0 -> out_uncorrectable 1, out_iter 0, out_codeword 0x00A4 at T+2.
- Backpressure: hold out_ready low 5 cycles after out_valid -> outputs stable, in_ready 0, and a second in_valid is not accepted until one cycle after out_ready.
- Assert rst_n low during ITER of a decode -> next cycle all outputs 0, no out_valid. The following encode of 0x01 still yields 0x8F01.

Source files
------------

// File: rtl/ldpc_bf_decoder_if.sv
// Request/result streaming bundle for the (16,8) LDPC bit-flipping codec.
// The master drives requests and consumes results; the codec is the slave.
interface ldpc_bf_decoder_if #(
  parameter int ITER_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_encode;
  logic [7:0]        in_data;
  logic [15:0]       in_codeword;
  logic [ITER_W-1:0] cfg_max_iter;
  logic              cfg_mode;
  logic [2:0]        cfg_threshold;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_codeword;
  logic [7:0]        out_data;
  logic [ITER_W-1:0] out_iter;
  logic              out_corrected;
  logic              out_uncorrectable;

  modport master (
    output in_valid, in_encode, in_data, in_codeword,
    output cfg_max_iter, cfg_mode, cfg_threshold, out_ready,
    input  in_ready, out_valid, out_codeword, out_data,
    input  out_iter, out_corrected, out_uncorrectable
  );

  modport slave (
    input  in_valid, in_encode, in_data, in_codeword,
    input  cfg_max_iter, cfg_mode, cfg_threshold, out_ready,
    output in_ready, out_valid, out_codeword, out_data,
    output out_iter, out_corrected, out_uncorrectable
  );
endinterface

// File: rtl/ldpc_bf_decoder.sv
// (16,8) LDPC encoder and iterative hard-decision bit-flipping decoder,
// one flip iteration per cycle, with early termination and output backpressure.
module ldpc_bf_decoder #(
  parameter int MAX_ITER_LIMIT = 15,
  parameter int ITER_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ldpc_bf_decoder_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [ITER_W-1:0] LIMIT_MAX = ITER_W'(MAX_ITER_LIMIT);

  logic [1:0]        r_state;
  logic              r_in_ready;
  logic [15:0]       r_word;
  logic [15:0]       r_rcv;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] r_limit;
  logic              r_mode;
  logic [2:0]        r_thr;
  logic              r_corrected;
  logic              r_uncorr;

  logic [1:0]        w_next;
  logic              w_accept;
  logic [7:0]        w_syn;
  logic [2:0]        w_vote [16];
  logic [2:0]        w_max;
  logic [15:0]       w_mask;

  function automatic logic [7:0] f_parity(input logic [7:0] u);
    logic [7:0] p;
    p[0] = u[0] ^ u[1] ^ u[2] ^ u[3];
    p[1] = u[0] ^ u[1] ^ u[4] ^ u[5];
    p[2] = u[0] ^ u[2] ^ u[4] ^ u[6];
    p[3] = u[0] ^ u[3] ^ u[4] ^ u[7];
    p[4] = u[1] ^ u[2] ^ u[5] ^ u[6];
    p[5] = u[1] ^ u[3] ^ u[5] ^ u[7];
    p[6] = u[2] ^ u[3] ^ u[6] ^ u[7];
    p[7] = u[0] ^ u[1] ^ u[2] ^ u[4] ^ u[6];
    return p;
  endfunction

  // in_ready is registered from the next state so it is low throughout reset.
  assign w_accept = bus.in_valid && r_in_ready;
  assign w_syn    = f_parity(r_word[7:0]) ^ r_word[15:8];

  // Each data bit's vote is the number of unsatisfied checks it takes part in.
  assign w_vote[0] = 3'(w_syn[0]) + 3'(w_syn[1]) + 3'(w_syn[2]) + 3'(w_syn[3]) + 3'(w_syn[7]);
  assign w_vote[1] = 3'(w_syn[0]) + 3'(w_syn[1]) + 3'(w_syn[4]) + 3'(w_syn[5]) + 3'(w_syn[7]);
  assign w_vote[2] = 3'(w_syn[0]) + 3'(w_syn[2]) + 3'(w_syn[4]) + 3'(w_syn[6]) + 3'(w_syn[7]);
  assign w_vote[3] = 3'(w_syn[0]) + 3'(w_syn[3]) + 3'(w_syn[5]) + 3'(w_syn[6]);
  assign w_vote[4] = 3'(w_syn[1]) + 3'(w_syn[2]) + 3'(w_syn[3]) + 3'(w_syn[7]);
  assign w_vote[5] = 3'(w_syn[1]) + 3'(w_syn[4]) + 3'(w_syn[5]);
  assign w_vote[6] = 3'(w_syn[2]) + 3'(w_syn[4]) + 3'(w_syn[6]) + 3'(w_syn[7]);
  assign w_vote[7] = 3'(w_syn[3]) + 3'(w_syn[5]) + 3'(w_syn[6]);
  for (genvar k = 0; k < 8; k++) begin : g_pvote
    assign w_vote[8+k] = 3'(w_syn[k]);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_max  = '0;
    w_mask = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_vote[i] > w_max) w_max = w_vote[i];
    end
    for (int i = 0; i < 16; i++) begin
      w_mask[i] = r_mode ? (w_vote[i] >= r_thr)
                         : ((w_max != 3'd0) && (w_vote[i] == w_max));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = bus.in_encode ? S_OUT : S_ITER;
      S_ITER: if ((w_syn == 8'd0) || (r_iter == r_limit)) w_next = S_OUT;
      S_OUT:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_word      <= '0;
      r_rcv       <= '0;
      r_iter      <= '0;
      r_limit     <= '0;
      r_mode      <= 1'b0;
      r_thr       <= '0;
      r_corrected <= 1'b0;
      r_uncorr    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_iter      <= '0;
          r_corrected <= 1'b0;
          r_uncorr    <= 1'b0;
          if (bus.in_encode) begin
            r_word <= {f_parity(bus.in_data), bus.in_data};
          end else begin
            r_word  <= bus.in_codeword;
            r_rcv   <= bus.in_codeword;
            r_limit <= (bus.cfg_max_iter > LIMIT_MAX) ? LIMIT_MAX : bus.cfg_max_iter;
            r_mode  <= bus.cfg_mode;
            r_thr   <= (bus.cfg_threshold == 3'd0) ? 3'd1 : bus.cfg_threshold;
          end
        end
        S_ITER: begin
          if (w_syn == 8'd0) begin
            r_corrected <= (r_word != r_rcv);
          end else if (r_iter == r_limit) begin
            r_uncorr <= 1'b1;
          end else begin
            r_word <= r_word ^ w_mask;
            r_iter <= r_iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready          = r_in_ready;
  assign bus.out_valid         = (r_state == S_OUT);
  assign bus.out_codeword      = r_word;
  assign bus.out_data          = r_word[7:0];
  assign bus.out_iter          = r_iter;
  assign bus.out_corrected     = r_corrected;
  assign bus.out_uncorrectable = r_uncorr;

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// Directed bench for ldpc_bf_decoder: encode, decode in both flip modes,
// iteration limit, backpressure and reset during an active decode.
module tb_ldpc_bf_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  ldpc_bf_decoder_if #(.ITER_W(4)) bus ();

  ldpc_bf_decoder #(.MAX_ITER_LIMIT(15), .ITER_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drives a request at a falling edge, waits for acceptance and returns at
  // the falling edge just after the accepting rising edge.
  task automatic do_req(input logic enc, input logic [7:0] data, input logic [15:0] cw,
                        input logic [3:0] lim, input logic mode, input logic [2:0] thr);
    int n;
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.in_encode     = enc;
    bus.in_data       = data;
    bus.in_codeword   = cw;
    bus.cfg_max_iter  = lim;
    bus.cfg_mode      = mode;
    bus.cfg_threshold = thr;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL accept_timeout: in_ready %b after %0d cycles, want 1", bus.in_ready, n);
    else passed++;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Latency in cycles from the accepting edge; 40 means out_valid never rose.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.out_valid, bus.in_ready, bus.out_corrected, bus.out_uncorrectable} !== 4'b0000)
      $display("FAIL reset_ctrl: valid/ready/corr/unc %b, want 0000",
               {bus.out_valid, bus.in_ready, bus.out_corrected, bus.out_uncorrectable});
    else passed++;
    total++;
    if ({bus.out_codeword, bus.out_data, bus.out_iter} !== 28'd0)
      $display("FAIL reset_data: cw %h data %h iter %0d, want 0", bus.out_codeword, bus.out_data, bus.out_iter);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_encode();
    int lat;
    do_req(1'b1, 8'h01, 16'h0000, 4'd0, 1'b0, 3'd0);
    wait_out(lat);
    total++;
    if (lat !== 1) $display("FAIL enc01_latency: got %0d want 1", lat); else passed++;
    total++;
    if (bus.out_codeword !== 16'h8F01) $display("FAIL enc01_cw: got %h want 8f01", bus.out_codeword); else passed++;
    total++;
    if ({bus.out_data, bus.out_iter, bus.out_corrected, bus.out_uncorrectable} !== {8'h01, 4'd0, 2'b00})
      $display("FAIL enc01_side: data %h iter %0d corr %b unc %b, want 01 0 0 0",
               bus.out_data, bus.out_iter, bus.out_corrected, bus.out_uncorrectable);
    else passed++;
    consume();
    do_req(1'b1, 8'hA5, 16'h0000, 4'd0, 1'b0, 3'd0);
    wait_out(lat);
    total++;
    if (bus.out_codeword !== 16'h00A5 || lat !== 1)
      $display("FAIL encA5_cw: got %h lat %0d want 00a5 lat 1", bus.out_codeword, lat);
    else passed++;
    consume();
  endtask

  task automatic test_decode_clean();
    int lat;
    do_req(1'b0, 8'h00, 16'h00A5, 4'd10, 1'b0, 3'd0);
    wait_out(lat);
    total++;
    if (lat !== 2) $display("FAIL clean_latency: got %0d want 2", lat); else passed++;
    total++;
    if ({bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable} !== {16'h00A5, 4'd0, 2'b00})
      $display("FAIL clean_result: cw %h iter %0d corr %b unc %b, want 00a5 0 0 0",
               bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable);
    else passed++;
    consume();
  endtask

  task automatic test_max_vote();
    int lat;
    do_req(1'b0, 8'h00, 16'h00A4, 4'd10, 1'b0, 3'd0);
    wait_out(lat);
    total++;
    if (lat !== 3) $display("FAIL maxvote_latency: got %0d want 3", lat); else passed++;
    total++;
    if ({bus.out_data, bus.out_iter, bus.out_corrected, bus.out_uncorrectable} !== {8'hA5, 4'd1, 2'b10})
      $display("FAIL maxvote_result: data %h iter %0d corr %b unc %b, want a5 1 1 0",
               bus.out_data, bus.out_iter, bus.out_corrected, bus.out_uncorrectable);
    else passed++;
    consume();
  endtask

  task automatic test_threshold();
    int lat;
    do_req(1'b0, 8'h00, 16'h00A4, 4'd10, 1'b1, 3'd5);
    wait_out(lat);
    total++;
    if ({bus.out_codeword, bus.out_iter, bus.out_corrected} !== {16'h00A5, 4'd1, 1'b1} || lat !== 3)
      $display("FAIL thr5_result: cw %h iter %0d corr %b lat %0d, want 00a5 1 1 3",
               bus.out_codeword, bus.out_iter, bus.out_corrected, lat);
    else passed++;
    consume();
    // No vote reaches 6: empty masks still consume iterations up to the limit.
    do_req(1'b0, 8'h00, 16'h00A4, 4'd3, 1'b1, 3'd6);
    wait_out(lat);
    total++;
    if ({bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable} !== {16'h00A4, 4'd3, 2'b01} || lat !== 5)
      $display("FAIL thr6_empty: cw %h iter %0d corr %b unc %b lat %0d, want 00a4 3 0 1 5",
               bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable, lat);
    else passed++;
    consume();
  endtask

  task automatic test_limit_zero();
    int lat;
    do_req(1'b0, 8'h00, 16'h00A4, 4'd0, 1'b1, 3'd5);
    wait_out(lat);
    total++;
    if (lat !== 2) $display("FAIL lim0_latency: got %0d want 2", lat); else passed++;
    total++;
    if ({bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable} !== {16'h00A4, 4'd0, 2'b01})
      $display("FAIL lim0_result: cw %h iter %0d corr %b unc %b, want 00a4 0 0 1",
               bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable);
    else passed++;
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    bus.out_ready = 1'b0;
    do_req(1'b1, 8'h01, 16'h0000, 4'd0, 1'b0, 3'd0);
    wait_out(lat);
    bus.in_valid  = 1'b1;
    bus.in_encode = 1'b1;
    bus.in_data   = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_codeword !== 16'h8F01) bad++;
      @(negedge clk);
    end
    total++;
    if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); else passed++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release: valid %b ready %b, want 0 1", bus.out_valid, bus.in_ready);
    else passed++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_codeword !== 16'h00A5)
      $display("FAIL bp_second: valid %b cw %h, want 1 00a5", bus.out_valid, bus.out_codeword);
    else passed++;
    consume();
  endtask

  task automatic test_reset_mid_iter();
    int lat;
    int seen = 0;
    do_req(1'b0, 8'h00, 16'h00A4, 4'd10, 1'b1, 3'd6);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.in_ready, bus.out_codeword, bus.out_iter, bus.out_corrected, bus.out_uncorrectable} !== 24'd0)
      $display("FAIL midreset_outputs: valid %b ready %b cw %h iter %0d, want all 0",
               bus.out_valid, bus.in_ready, bus.out_codeword, bus.out_iter);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) $display("FAIL midreset_no_output: out_valid seen %0d cycles, want 0", seen); else passed++;
    do_req(1'b1, 8'h01, 16'h0000, 4'd0, 1'b0, 3'd0);
    wait_out(lat);
    total++;
    if (bus.out_codeword !== 16'h8F01 || lat !== 1)
      $display("FAIL midreset_encode: cw %h lat %0d, want 8f01 1", bus.out_codeword, lat);
    else passed++;
    consume();
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_encode     = 1'b0;
    bus.in_data       = '0;
    bus.in_codeword   = '0;
    bus.cfg_max_iter  = '0;
    bus.cfg_mode      = 1'b0;
    bus.cfg_threshold = '0;
    bus.out_ready     = 1'b1;
    test_reset();
    test_encode();
    test_decode_clean();
    test_max_vote();
    test_threshold();
    test_limit_zero();
    test_back_to_back();
    test_reset_mid_iter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
